// File: rtl/fluid_board_input_debounce.sv
// Input conditioner for board sensors feeding a PIO in_port. Each bit passes through a
// 2-FF synchronizer, optional inversion and a consecutive-sample debounce filter.
module fluid_board_input_debounce #(
  parameter int                 WIDTH       = 15,
  parameter int                 CNT_W       = 16,
  parameter logic [WIDTH-1:0]   INVERT_MASK = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   raw_in,
  input  logic [CNT_W-1:0]   debounce_cycles,
  input  logic [WIDTH-1:0]   clear_changed,
  input  logic               glitch_clr,
  output logic [WIDTH-1:0]   out_port,
  output logic [WIDTH-1:0]   change_pulse,
  output logic [WIDTH-1:0]   changed,
  output logic [15:0]        glitch_cnt
);

  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] pulse_q, pulse_d;
  logic [WIDTH-1:0] changed_q, changed_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [15:0]      glitch_q, glitch_d;

  logic [WIDTH-1:0] v;
  logic [WIDTH-1:0] reject;
  logic [CNT_W-1:0] n_eff;
  logic [16:0]      glitch_sum;

  assign s1_d  = raw_in;
  assign s2_d  = s1_q;
  assign v     = s2_q ^ INVERT_MASK;
  assign n_eff = (debounce_cycles == '0) ? CNT_W'(1) : debounce_cycles;

  // Per bit the filter is STABLE when cnt is 0 and QUALIFY otherwise; cnt stays below N.
  always_comb begin
    out_d   = out_q;
    pulse_d = '0;
    reject  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (v[i] != out_q[i]) begin
        if (({1'b0, cnt_q[i]} + (CNT_W+1)'(1)) >= {1'b0, n_eff}) begin
          out_d[i]   = v[i];
          pulse_d[i] = 1'b1;
          cnt_d[i]   = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else if (cnt_q[i] != '0) begin
        reject[i] = 1'b1;
        cnt_d[i]  = '0;
      end
    end
  end

  // A toggle on the same edge as a clear leaves the flag set.
  assign changed_d = (changed_q & ~clear_changed) | pulse_d;

  always_comb begin
    glitch_sum = {1'b0, glitch_q};
    for (int i = 0; i < WIDTH; i++) begin
      glitch_sum = glitch_sum + 17'(reject[i]);
    end
    if (glitch_clr) begin
      glitch_d = '0;
    end else if (glitch_sum[16]) begin
      glitch_d = 16'hFFFF;
    end else begin
      glitch_d = glitch_sum[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q      <= '0;
      s2_q      <= '0;
      out_q     <= '0;
      pulse_q   <= '0;
      changed_q <= '0;
      glitch_q  <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      out_q     <= out_d;
      pulse_q   <= pulse_d;
      changed_q <= changed_d;
      glitch_q  <= glitch_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign out_port     = out_q;
  assign change_pulse = pulse_q;
  assign changed      = changed_q;
  assign glitch_cnt   = glitch_q;

endmodule
